// File: rtl/axi_excl_monitor.sv
// AXI exclusive-access (LR/SC) reservation monitor with NUM_RSV per-ID granule reservations.
// Optional reservation lifetime counters are enabled by defining AXI_EXCL_TIMEOUT_EN.
module axi_excl_monitor #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned NUM_RSV        = 4,
  parameter int unsigned GRAN_BITS      = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         ar_hs_i,
  input  logic                         ar_lock_i,
  input  logic [ID_WIDTH-1:0]          ar_id_i,
  input  logic [ADDR_WIDTH-1:0]        ar_addr_i,
  input  logic                         aw_valid_i,
  output logic                         aw_ready_o,
  input  logic                         aw_lock_i,
  input  logic [ID_WIDTH-1:0]          aw_id_i,
  input  logic [ADDR_WIDTH-1:0]        aw_addr_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic                         res_exokay_o,
  output logic                         res_do_write_o,
  output logic [ID_WIDTH-1:0]          res_id_o,
  output logic [$clog2(NUM_RSV+1)-1:0] rsv_count_o
);

  localparam int unsigned TagW    = ADDR_WIDTH - GRAN_BITS;
  localparam int unsigned IdxW    = (NUM_RSV > 1) ? $clog2(NUM_RSV) : 1;
  localparam int unsigned CountW  = $clog2(NUM_RSV + 1);

  logic [NUM_RSV-1:0]  valid_q, valid_d;
  logic [ID_WIDTH-1:0] id_q  [NUM_RSV];
  logic [ID_WIDTH-1:0] id_d  [NUM_RSV];
  logic [TagW-1:0]     tag_q [NUM_RSV];
  logic [TagW-1:0]     tag_d [NUM_RSV];
  logic [IdxW-1:0]     ptr_q, ptr_d;

  logic                res_valid_q, res_valid_d;
  logic                res_exokay_q;
  logic                res_do_write_q;
  logic [ID_WIDTH-1:0] res_id_q;

  logic                aw_hs;
  logic                ar_set;
  logic                sc_pass;
  logic [TagW-1:0]     aw_tag;
  logic [TagW-1:0]     ar_tag;
  logic                slot_found;
  logic [IdxW-1:0]     slot_idx;

  // Sub-granule address bits never take part in matching.
  logic unused_addr;
  assign unused_addr = ^{ar_addr_i[GRAN_BITS-1:0], aw_addr_i[GRAN_BITS-1:0]};

  assign aw_tag     = aw_addr_i[ADDR_WIDTH-1:GRAN_BITS];
  assign ar_tag     = ar_addr_i[ADDR_WIDTH-1:GRAN_BITS];
  assign aw_ready_o = rst_ni & (~res_valid_q | res_ready_i);
  assign aw_hs      = aw_valid_i & aw_ready_o;
  assign ar_set     = ar_hs_i & ar_lock_i;

`ifdef AXI_EXCL_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0]    cnt_q [NUM_RSV];
  logic [NUM_RSV-1:0] set_en;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_RSV; i++) begin
      if (!rst_ni || set_en[i]) begin
        cnt_q[i] <= '0;
      end else if (valid_q[i] && cnt_q[i] != CntLast) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // SC is always judged against the pre-cycle reservation state.
  always_comb begin
    sc_pass = 1'b0;
    for (int i = 0; i < NUM_RSV; i++) begin
      if (valid_q[i] && id_q[i] == aw_id_i && tag_q[i] == aw_tag) begin
        sc_pass = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    id_d       = id_q;
    tag_d      = tag_q;
    ptr_d      = ptr_q;
    slot_found = 1'b0;
    slot_idx   = '0;
`ifdef AXI_EXCL_TIMEOUT_EN
    set_en = '0;
    for (int i = 0; i < NUM_RSV; i++) begin
      if (valid_q[i] && cnt_q[i] == CntLast) begin
        valid_d[i] = 1'b0;
      end
    end
`endif

    if (aw_hs) begin
      for (int i = 0; i < NUM_RSV; i++) begin
        if (valid_q[i]) begin
          if (aw_lock_i && !sc_pass) begin
            // Failed SC still consumes this ID's (different-granule) reservation.
            if (id_q[i] == aw_id_i) begin
              valid_d[i] = 1'b0;
            end
          end else if (tag_q[i] == aw_tag) begin
            valid_d[i] = 1'b0;
          end
        end
      end
    end

    // Reservation placement sees the post-invalidation state so a new LR survives.
    if (ar_set) begin
      for (int i = 0; i < NUM_RSV; i++) begin
        if (!slot_found && valid_d[i] && id_d[i] == ar_id_i) begin
          slot_found = 1'b1;
          slot_idx   = IdxW'(i);
        end
      end
      for (int i = 0; i < NUM_RSV; i++) begin
        if (!slot_found && !valid_d[i]) begin
          slot_found = 1'b1;
          slot_idx   = IdxW'(i);
        end
      end
      if (!slot_found) begin
        slot_idx = ptr_q;
        ptr_d    = (ptr_q == IdxW'(NUM_RSV - 1)) ? '0 : ptr_q + 1'b1;
      end
      valid_d[slot_idx] = 1'b1;
      id_d[slot_idx]    = ar_id_i;
      tag_d[slot_idx]   = ar_tag;
`ifdef AXI_EXCL_TIMEOUT_EN
      set_en[slot_idx]  = 1'b1;
`endif
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    if (aw_hs) begin
      res_valid_d = 1'b1;
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q        <= '0;
      ptr_q          <= '0;
      res_valid_q    <= 1'b0;
      res_exokay_q   <= 1'b0;
      res_do_write_q <= 1'b0;
      res_id_q       <= '0;
      for (int i = 0; i < NUM_RSV; i++) begin
        id_q[i]  <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
      if (aw_hs) begin
        res_exokay_q   <= aw_lock_i & sc_pass;
        res_do_write_q <= ~aw_lock_i | sc_pass;
        res_id_q       <= aw_id_i;
      end
    end
  end

  always_comb begin
    rsv_count_o = '0;
    for (int i = 0; i < NUM_RSV; i++) begin
      rsv_count_o = rsv_count_o + CountW'(valid_q[i]);
    end
  end

  assign res_valid_o    = res_valid_q;
  assign res_exokay_o   = res_exokay_q;
  assign res_do_write_o = res_do_write_q;
  assign res_id_o       = res_id_q;

endmodule

// File: tb/tb_axi_excl_monitor.sv
// Scoreboard bench for axi_excl_monitor: directed LR/SC scenarios followed by random traffic,
// checked against a reservation-table reference model.
module tb_axi_excl_monitor;

  localparam int NRSV = 4;

  typedef struct packed {
    logic       exokay;
    logic       do_write;
    logic [3:0] id;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        ar_hs, ar_lock;
  logic [3:0]  ar_id;
  logic [63:0] ar_addr;
  logic        aw_valid, aw_ready, aw_lock;
  logic [3:0]  aw_id;
  logic [63:0] aw_addr;
  logic        res_valid, res_ready, res_exokay, res_do_write;
  logic [3:0]  res_id;
  logic [2:0]  rsv_count;

  axi_excl_monitor dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ar_hs_i       (ar_hs),
    .ar_lock_i     (ar_lock),
    .ar_id_i       (ar_id),
    .ar_addr_i     (ar_addr),
    .aw_valid_i    (aw_valid),
    .aw_ready_o    (aw_ready),
    .aw_lock_i     (aw_lock),
    .aw_id_i       (aw_id),
    .aw_addr_i     (aw_addr),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_exokay_o  (res_exokay),
    .res_do_write_o(res_do_write),
    .res_id_o      (res_id),
    .rsv_count_o   (rsv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  res_t sb[$];

  // Reference model: a table of reservations plus a round-robin victim pointer.
  bit          m_valid [NRSV];
  logic [3:0]  m_id    [NRSV];
  logic [57:0] m_tag   [NRSV];
  int          m_ptr;
  bit          m_res_valid;

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NRSV; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NRSV; i++) m_valid[i] = 0;
    m_ptr       = 0;
    m_res_valid = 0;
    sb.delete();
  endtask

  task automatic model_step(input bit acc, input bit arh, input bit arl, input logic [3:0] arid,
                            input logic [63:0] ara, input bit awl, input logic [3:0] awid,
                            input logic [63:0] awa, input bit rr);
    bit   pass;
    int   slot;
    res_t r;
    pass = 0;
    for (int i = 0; i < NRSV; i++)
      if (m_valid[i] && m_id[i] == awid && m_tag[i] == awa[63:6]) pass = 1;
    if (acc) begin
      r.exokay   = awl && pass;
      r.do_write = !awl || pass;
      r.id       = awid;
      sb.push_back(r);
      for (int i = 0; i < NRSV; i++) begin
        if (awl && !pass) begin
          if (m_id[i] == awid) m_valid[i] = 0;
        end else if (m_tag[i] == awa[63:6]) begin
          m_valid[i] = 0;
        end
      end
    end
    if (arh && arl) begin
      slot = -1;
      for (int i = 0; i < NRSV; i++) if (slot < 0 && m_valid[i] && m_id[i] == arid) slot = i;
      for (int i = 0; i < NRSV; i++) if (slot < 0 && !m_valid[i]) slot = i;
      if (slot < 0) begin
        slot  = m_ptr;
        m_ptr = (m_ptr + 1) % NRSV;
      end
      m_valid[slot] = 1;
      m_id[slot]    = arid;
      m_tag[slot]   = ara[63:6];
    end
    m_res_valid = acc ? 1'b1 : (rr ? 1'b0 : m_res_valid);
  endtask

  // One clock of stimulus: check registered state, drive, check ready, advance the model.
  task automatic step(input bit arh, input bit arl, input logic [3:0] arid, input logic [63:0] ara,
                      input bit awv, input bit awl, input logic [3:0] awid, input logic [63:0] awa,
                      input bit rr);
    bit exp_ready;
    @(posedge clk);
    #1;
    n_cmp++;
    if (int'(rsv_count) != model_count()) begin
      n_err++;
      $display("FAIL rsv_count: got %0d want %0d @%0t", rsv_count, model_count(), $time);
    end
    ar_hs = arh; ar_lock = arl; ar_id = arid; ar_addr = ara;
    aw_valid = awv; aw_lock = awl; aw_id = awid; aw_addr = awa;
    res_ready = rr;
    #1;
    exp_ready = !m_res_valid || rr;
    n_cmp++;
    if (aw_ready !== exp_ready) begin
      n_err++;
      $display("FAIL aw_ready: got %b want %b @%0t", aw_ready, exp_ready, $time);
    end
    model_step(awv && exp_ready, arh, arl, arid, ara, awl, awid, awa, rr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0;
    ar_hs = 0; ar_lock = 0; aw_valid = 0; aw_lock = 0; res_ready = 0;
    #1;
    n_cmp++;
    if (aw_ready !== 1'b0) begin
      n_err++;
      $display("FAIL aw_ready_in_reset: got %b want 0", aw_ready);
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (res_valid !== 1'b0 || rsv_count !== 3'd0 || res_id !== 4'd0 || res_exokay !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b cnt=%0d id=%0d exo=%b want 0/0/0/0",
               res_valid, rsv_count, res_id, res_exokay);
    end
    rst_n = 1;
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] b;
    case ($urandom % 5)
      0:       b = 64'h1000;
      1:       b = 64'h1040;
      2:       b = 64'h2000;
      3:       b = 64'hFFFF_0000_0000_1000;
      default: b = 64'h3000;
    endcase
    return b | 64'($urandom % 64);
  endfunction

  // Monitor: pops the scoreboard on every result handshake.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      res_t exp_r;
      res_t got_r;
      got_r = '{exokay: res_exokay, do_write: res_do_write, id: res_id};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL result: got unexpected %h want none @%0t", got_r, $time);
      end else begin
        exp_r = sb.pop_front();
        if (got_r !== exp_r) begin
          n_err++;
          $display("FAIL result: got exo=%b wr=%b id=%0d want exo=%b wr=%b id=%0d @%0t",
                   got_r.exokay, got_r.do_write, got_r.id,
                   exp_r.exokay, exp_r.do_write, exp_r.id, $time);
        end
      end
    end
  end

  initial begin
    rst_n = 0;
    ar_hs = 0; ar_lock = 0; ar_id = 0; ar_addr = 0;
    aw_valid = 0; aw_lock = 0; aw_id = 0; aw_addr = 0; res_ready = 0;
    model_clear();
    do_reset();

    // LR then SC in the same granule.
    step(1, 1, 1, 64'h1000, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1, 1, 64'h1020, 1);
    idle(2);

    // Plain write to the reserved granule kills the reservation.
    step(1, 1, 2, 64'h2000, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 5, 64'h203F, 1);
    step(0, 0, 0, 0, 1, 1, 2, 64'h2000, 1);
    idle(2);

    // Fill all entries then force a victim replacement.
    for (int i = 0; i < 5; i++) step(1, 1, 4'(i), 64'h4000 + 64'(i) * 64'h100, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1, 0, 64'h4000, 1);
    step(0, 0, 0, 0, 1, 1, 1, 64'h4100, 1);
    idle(2);

    // Result back-pressure: queries held off while the result is stalled.
    step(0, 0, 0, 0, 1, 0, 7, 64'h5000, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 8, 64'h6000, 0);
    step(0, 0, 0, 0, 1, 0, 9, 64'h7000, 1);
    idle(2);

    // Same-cycle LR and plain write to that granule: the new reservation survives.
    step(1, 1, 3, 64'h3000, 1, 0, 6, 64'h3000, 1);
    step(0, 0, 0, 0, 1, 1, 3, 64'h3000, 1);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        step(0, 0, 0, 0, 1, 1, 2, 64'h1000, 0);
        do_reset();
      end
      step(($urandom % 3) == 0, ($urandom % 4) != 0, 4'($urandom % 6), rand_addr(),
           ($urandom % 2) == 1, ($urandom % 2) == 1, 4'($urandom % 6), rand_addr(),
           ($urandom % 4) != 0);
    end
    idle(5);

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending results want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
